// File: rtl/signed_mult_arbiter.sv
// signed_mult_arbiter
//
// Round-robin arbiter and sequencer in front of one shared combinational
// DATA_W x DATA_W signed multiplier. Two requesters offer operand pairs over
// valid/ready. The winning pair is registered onto the multiplier inputs and
// held for SETTLE_CYCLES cycles. The product is then captured and returned
// with the owner's ID over a response handshake. Only one operation is in
// flight at a time.
//
// Ports:
//   clk_in          clock, rising edge
//   rst_in          synchronous reset, active-high
//   req0_valid_in   requester 0 offers an operand pair
//   req0_ready_out  requester 0 pair accepted when valid & ready
//   req0_a_in       requester 0 multiplicand (signed)
//   req0_b_in       requester 0 multiplier (signed)
//   req1_valid_in   requester 1 offers an operand pair
//   req1_ready_out  requester 1 pair accepted when valid & ready
//   req1_a_in       requester 1 multiplicand (signed)
//   req1_b_in       requester 1 multiplier (signed)
//   mul_a_out       registered operand A to the shared multiplier
//   mul_b_out       registered operand B to the shared multiplier
//   mul_result_in   product from the shared multiplier
//   rsp_valid_out   product available
//   rsp_ready_in    consumer accepts the product
//   rsp_id_out      requester that owns the product
//   rsp_result_out  captured signed product
//   busy_out        high whenever the sequencer is not idle
//   op_count_out    completed responses, wraps 255 -> 0

module signed_mult_arbiter #(
    parameter int unsigned DATA_W        = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,

    input  logic                  req0_valid_in,
    output logic                  req0_ready_out,
    input  logic [DATA_W-1:0]     req0_a_in,
    input  logic [DATA_W-1:0]     req0_b_in,

    input  logic                  req1_valid_in,
    output logic                  req1_ready_out,
    input  logic [DATA_W-1:0]     req1_a_in,
    input  logic [DATA_W-1:0]     req1_b_in,

    output logic [DATA_W-1:0]     mul_a_out,
    output logic [DATA_W-1:0]     mul_b_out,
    input  logic [2*DATA_W-1:0]   mul_result_in,

    output logic                  rsp_valid_out,
    input  logic                  rsp_ready_in,
    output logic                  rsp_id_out,
    output logic [2*DATA_W-1:0]   rsp_result_out,

    output logic                  busy_out,
    output logic [7:0]            op_count_out
);

    // The counter is loaded with SETTLE_CYCLES-1 on accept and the product
    // is captured in the SETTLE cycle where it reads zero.
    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StResp
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     mul_a_q, mul_a_d;
    logic [DATA_W-1:0]     mul_b_q, mul_b_d;
    logic                  id_q, id_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [2*DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic [7:0]            op_count_q, op_count_d;

    logic                  gnt0, gnt1;

    // Grant: a lone requester always wins. Under contention the requester
    // that was not served last wins. Nothing is granted outside IDLE.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StIdle) begin
            if (req0_valid_in && req1_valid_in) begin
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = req0_valid_in;
                gnt1 = req1_valid_in;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        op_count_d   = op_count_q;

        unique case (state_q)
            StIdle: begin
                if (gnt0 || gnt1) begin
                    mul_a_d      = gnt1 ? req1_a_in : req0_a_in;
                    mul_b_d      = gnt1 ? req1_b_in : req0_b_in;
                    id_d         = gnt1;
                    last_grant_d = gnt1;
                    cnt_d        = SettleLoad;
                    state_d      = StSettle;
                end
            end

            StSettle: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_result_d = mul_result_in;
                    rsp_valid_d  = 1'b1;
                    state_d      = StResp;
                end
            end

            StResp: begin
                if (rsp_ready_in) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 8'd1;
                    state_d     = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            id_q         <= 1'b0;
            cnt_q        <= 4'd0;
            // Requester 0 wins the first contention after reset.
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            op_count_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            op_count_q   <= op_count_d;
        end
    end

    assign req0_ready_out = gnt0;
    assign req1_ready_out = gnt1;
    assign mul_a_out      = mul_a_q;
    assign mul_b_out      = mul_b_q;
    assign rsp_valid_out  = rsp_valid_q;
    assign rsp_id_out     = id_q;
    assign rsp_result_out = rsp_result_q;
    assign op_count_out   = op_count_q;
    assign busy_out       = (state_q != StIdle);

endmodule

// File: tb/tb_signed_mult_arbiter.sv
// Testbench for signed_mult_arbiter: directed scenarios followed by random
// traffic. A grant/accept monitor pushes expected responses into a queue,
// and a response monitor pops and compares them.

module tb_signed_mult_arbiter;

    localparam int unsigned DW = 4;
    localparam int unsigned S  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_in;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [DW-1:0] mul_a, mul_b;
    logic [2*DW-1:0] mul_result;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [2*DW-1:0] rsp_result;
    logic          busy;
    logic [7:0]    op_count;

    signed_mult_arbiter #(
        .DATA_W        (DW),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .req0_valid_in  (req0_valid),
        .req0_ready_out (req0_ready),
        .req0_a_in      (req0_a),
        .req0_b_in      (req0_b),
        .req1_valid_in  (req1_valid),
        .req1_ready_out (req1_ready),
        .req1_a_in      (req1_a),
        .req1_b_in      (req1_b),
        .mul_a_out      (mul_a),
        .mul_b_out      (mul_b),
        .mul_result_in  (mul_result),
        .rsp_valid_out  (rsp_valid),
        .rsp_ready_in   (rsp_ready),
        .rsp_id_out     (rsp_id),
        .rsp_result_out (rsp_result),
        .busy_out       (busy),
        .op_count_out   (op_count)
    );

    // Signed 4x4 product, low 8 bits of the sign-extended multiply.
    function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
        return sa * sb;
    endfunction

    // Stand-in for the external shared multiplier.
    assign mul_result = smul(mul_a, mul_b);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       id;
        logic [7:0] res;
        int         acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   acc_n  = 0;
    int   done_n = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Grant/accept monitor: predicts readys from the round-robin rules and
    // records each accepted pair as an expected response.
    initial begin : acc_mon
        logic       model_last;
        logic       busy_exp, e0, e1, id;
        logic [3:0] cur_a, cur_b;
        int         cur_acc;
        model_last = 1'b1;
        cur_a = '0;
        cur_b = '0;
        cur_acc = -100;
        forever begin
            @(negedge clk);
            #1;
            if (rst_in) begin
                model_last = 1'b1;
                cur_acc = -100;
            end else begin
                busy_exp = (acc_n != done_n);
                chk("busy", 64'(busy), 64'(busy_exp));
                if (busy_exp) begin
                    e0 = 1'b0;
                    e1 = 1'b0;
                end else if (req0_valid && req1_valid) begin
                    e0 = model_last;
                    e1 = !model_last;
                end else begin
                    e0 = req0_valid;
                    e1 = req1_valid;
                end
                chk("ready", 64'({req0_ready, req1_ready}), 64'({e0, e1}));
                if (busy_exp && cyc <= cur_acc + int'(S))
                    chk("mul_hold", 64'({mul_a, mul_b}), 64'({cur_a, cur_b}));
                if (e0 || e1) begin
                    id = e1;
                    cur_a = id ? req1_a : req0_a;
                    cur_b = id ? req1_b : req0_b;
                    cur_acc = cyc;
                    sb_q.push_back('{id: id, res: smul(cur_a, cur_b), acc_cyc: cyc});
                    model_last = id;
                    acc_n++;
                end
            end
        end
    end

    // Response monitor: latency, payload, stability and op_count.
    initial begin : rsp_mon
        logic [7:0] model_cnt;
        logic       rst_prev;
        model_cnt = 8'd0;
        rst_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_in) begin
                sb_q.delete();
                done_n = acc_n;
                model_cnt = 8'd0;
                rst_prev = 1'b1;
            end else begin
                if (rst_prev)
                    chk("reset_outputs",
                        64'({mul_a, mul_b, rsp_valid, rsp_id, rsp_result, op_count, busy}),
                        64'(0));
                rst_prev = 1'b0;
                chk("op_count", 64'(op_count), 64'(model_cnt));
                if (sb_q.size() > 0 && cyc == sb_q[0].acc_cyc + 1 + int'(S))
                    chk("latency", 64'(rsp_valid), 64'(1));
                if (rsp_valid) begin
                    if (sb_q.size() == 0 || cyc < sb_q[0].acc_cyc + 1 + int'(S)) begin
                        chk("spurious_rsp", 64'(rsp_valid), 64'(0));
                    end else begin
                        chk("rsp_id", 64'(rsp_id), 64'(sb_q[0].id));
                        chk("rsp_result", 64'(rsp_result), 64'(sb_q[0].res));
                        if (rsp_ready) begin
                            void'(sb_q.pop_front());
                            done_n++;
                            model_cnt = model_cnt + 8'd1;
                        end
                    end
                end
            end
        end
    end

    // Stimulus state: a pending operand pair per requester.
    logic       p0, p1, rr;
    logic [3:0] pa0, pb0, pa1, pb1;

    task automatic cycle();
        @(negedge clk);
        req0_valid = p0;
        req0_a     = pa0;
        req0_b     = pb0;
        req1_valid = p1;
        req1_a     = pa1;
        req1_b     = pb1;
        rsp_ready  = rr;
        #3;
        if (req0_valid && req0_ready) p0 = 1'b0;
        if (req1_valid && req1_ready) p1 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (p0 || p1 || acc_n != done_n) begin
            cycle();
            n++;
            if (n > 200) begin
                $display("FAIL drain_timeout: got %0d pending expected 0", acc_n - done_n);
                $fatal(1, "drain timeout");
            end
        end
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        while (p0 || p1) begin
            cycle();
            n++;
            if (n > 50) begin
                $display("FAIL accept_timeout: got pending expected accepted");
                $fatal(1, "accept timeout");
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_in     = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b0;
        p0 = 1'b0;
        p1 = 1'b0;
        @(negedge clk);
        rst_in = 1'b0;
    endtask

    initial begin : stim
        int n;
        rst_in = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        p0 = 1'b0; p1 = 1'b0; rr = 1'b0;
        pa0 = '0; pb0 = '0; pa1 = '0; pb1 = '0;
        repeat (3) @(negedge clk);
        rst_in = 1'b0;

        // Single request: -3 * 5 = -15.
        rr = 1'b1;
        p0 = 1'b1; pa0 = 4'hD; pb0 = 4'h5;
        drain();

        // Contention after reset: req0 first, then req1, then req0 again.
        do_reset();
        rr = 1'b1;
        p0 = 1'b1; pa0 = 4'h7; pb0 = 4'h7;
        p1 = 1'b1; pa1 = 4'h8; pb1 = 4'h8;
        drain();
        p0 = 1'b1; pa0 = 4'h1; pb0 = 4'h2;
        p1 = 1'b1; pa1 = 4'h3; pb1 = 4'h4;
        drain();

        // Backpressure: 7 * -8 held while req1 waits.
        rr = 1'b0;
        p0 = 1'b1; pa0 = 4'h7; pb0 = 4'h8;
        wait_accept();
        p1 = 1'b1; pa1 = 4'h2; pb1 = 4'h3;
        repeat (9) cycle();
        rr = 1'b1;
        drain();

        // Reset during SETTLE, then contention must favour req0.
        p0 = 1'b1; pa0 = 4'h3; pb0 = 4'h3;
        wait_accept();
        do_reset();
        rr = 1'b1;
        p0 = 1'b1; pa0 = 4'h1; pb0 = 4'hF;
        p1 = 1'b1; pa1 = 4'h2; pb1 = 4'h2;
        drain();

        // Reset during RESP.
        rr = 1'b0;
        p1 = 1'b1; pa1 = 4'h5; pb1 = 4'h5;
        n = 0;
        while (!rsp_valid && n < 20) begin
            cycle();
            n++;
        end
        do_reset();
        rr = 1'b1;
        p0 = 1'b1; pa0 = 4'h6; pb0 = 4'hA;
        p1 = 1'b1; pa1 = 4'h4; pb1 = 4'hC;
        drain();

        // Random traffic, long enough for op_count to wrap past 255.
        for (int i = 0; i < 3000; i++) begin
            if (!p0 && ($urandom % 2 == 0)) begin
                p0 = 1'b1; pa0 = 4'($urandom); pb0 = 4'($urandom);
            end else if (p0 && ($urandom % 10 == 0)) begin
                p0 = 1'b0;
            end
            if (!p1 && ($urandom % 2 == 0)) begin
                p1 = 1'b1; pa1 = 4'($urandom); pb1 = 4'($urandom);
            end else if (p1 && ($urandom % 10 == 0)) begin
                p1 = 1'b0;
            end
            rr = ($urandom % 4) != 0;
            cycle();
        end
        rr = 1'b1;
        drain();
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_mult_arbiter.md
Name: signed_mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational 4x4 signed (two's-complement) multiplier between two requesters. It accepts operand pairs over valid/ready handshakes and registers them onto the shared multiplier's inputs. It waits a programmable settle time, captures the 8-bit product and returns it with the requester ID over a response handshake. It sits between the two operand sources and the existing signed_multiplier instance; the multiplier itself is outside this block.

Parameters:
DATA_W, 4, operand width; product width is 2*DATA_W; only 4 is supported with the current multiplier.
SETTLE_CYCLES, 1, cycles operands are held on the multiplier before the product is captured; legal range 1..15.

Ports:
clk_in  input  1  clock; all logic on rising edge
rst_in  input  1  synchronous reset, active-high
req0_valid_in  input  1  requester 0 has an operand pair
req0_ready_out  output  1  requester 0 pair accepted this cycle when valid&ready
req0_a_in  input  DATA_W  requester 0 multiplicand, signed
req0_b_in  input  DATA_W  requester 0 multiplier, signed
req1_valid_in  input  1  requester 1 has an operand pair
req1_ready_out  output  1  requester 1 handshake ready
req1_a_in  input  DATA_W  requester 1 multiplicand, signed
req1_b_in  input  DATA_W  requester 1 multiplier, signed
mul_a_out  output  DATA_W  registered operand to the shared multiplier A_in
mul_b_out  output  DATA_W  registered operand to the shared multiplier B_in
mul_result_in  input  2*DATA_W  shared multiplier result_out
rsp_valid_out  output  1  product available
rsp_ready_in  input  1  consumer accepts the response
rsp_id_out  output  1  requester that owns the product (0/1)
rsp_result_out  output  2*DATA_W  signed product
busy_out  output  1  high in any state other than IDLE
op_count_out  output  8  completed responses, wraps 255->0

Behaviour:
- Reset, synchronous, wins over all other activity:
  - State goes to IDLE.
  - These outputs clear to 0: mul_a_out, mul_b_out, rsp_valid_out, rsp_id_out, rsp_result_out, op_count_out.
  - Settle counter clears to 0.
  - last_grant is set to 1, so requester 0 has priority on the first contention.
  - An in-flight operation is dropped and no response is produced for it.
- States:
  - IDLE: readys are driven per the grant rules.
    - On accept: register the operands onto mul_a_out/mul_b_out, latch the ID, load the settle counter with SETTLE_CYCLES-1, set last_grant to the ID, go to SETTLE.
    - With no valid input: stay in IDLE.
  - SETTLE: mul_a_out/mul_b_out hold stable.
    - Counter nonzero: decrement.
    - Counter zero: capture mul_result_in into rsp_result_out, assert rsp_valid_out, go to RESP.
  - RESP: rsp_valid_out, rsp_id_out and rsp_result_out hold stable until rsp_ready_in=1.
    - On that cycle: clear rsp_valid_out, increment op_count_out, go to IDLE.
- Grant rules, IDLE only, combinational from the valids and last_grant:
  - Only one valid: that requester gets ready.
  - Both valid: the requester other than last_grant gets ready.
  - At most one ready is high in any cycle.
  - Both readys are 0 outside IDLE.
- Latency: accept in cycle T -> rsp_valid_out high from cycle T+1+SETTLE_CYCLES.
- Throughput: new accepts are possible from the cycle after the response handshake, so at best 1 operation per SETTLE_CYCLES+2 cycles.
- A requester that drops valid before it is granted loses nothing; the arbiter never latches ungranted operands.
- A requester holding valid high while the other is served is served next. Fairness: a waiting requester never waits more than one operation.
- rsp_ready_in high while rsp_valid_out is low is ignored.
- Arithmetic: no arithmetic in this block. The product is passed through unchanged and interpreted as 8-bit two's complement. Operands are passed unchanged; no sign extension or saturation.
- busy_out = (state != IDLE), registered with the state.

Test Plan:
1. Reset, then a single request: req0 a=4'hD (-3), b=4'h5 -> accepted the same cycle; with SETTLE_CYCLES=1, rsp_valid two cycles later with id=0, result=8'hF1 (-15); op_count=1.
2. Both valid in the same cycle after reset: req0 (7,7), req1 (-8,-8) -> req0 is served first with 8'h31, then req1 with 8'h40. Then both valid again -> req0 is served (last_grant=1 after req1).
3. Backpressure: request 7*-8; hold rsp_ready_in=0 for 5 cycles -> rsp_valid, id and result=8'hC8 stay stable, no new accept while the other requester is valid, op_count changes only on the handshake.
4. SETTLE_CYCLES=3: accept at cycle T -> mul_a/mul_b stable T+1..T+3, rsp_valid at T+4; product equals the multiplier output sampled at the end of T+3.
5. Reset asserted during SETTLE, then during RESP -> all outputs 0 the next cycle, no response emitted, op_count=0, and the next contention grants req0.
6. op_count wrap: 256 back-to-back completed operations -> op_count_out returns to 8'h00.
